seq_decoder: RTL and testbench

SEQ_DECODER -- requirements
Module: seq_decoder

---
 rtl/seq_decoder_pkg.sv | 34 +++
 rtl/seq_decoder_core.sv | 30 +++
 rtl/seq_decoder.sv | 86 ++++++++
 tb/tb_seq_decoder.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/seq_decoder_pkg.sv
// seq_decoder shared types and decode helpers.
// Mode encoding plus the per-bit decode rule used by the core.
package seq_decoder_pkg;

    localparam int MAX_N = 6;

    typedef enum logic [1:0] {
        MODE_ONEHOT   = 2'd0,
        MODE_THERM    = 2'd1,
        MODE_ONEHOT_N = 2'd2,
        MODE_RSVD     = 2'd3
    } mode_e;

    function automatic logic decode_bit(
        input logic [MAX_N-1:0] code,
        input mode_e            mode,
        input logic [MAX_N-1:0] k
    );
        logic b;
        b = 1'b0;
        unique case (mode)
            MODE_ONEHOT:   b = (k == code);
            MODE_THERM:    b = (k <= code);
            MODE_ONEHOT_N: b = (k != code);
            default:       b = 1'b0;
        endcase
        return b;
    endfunction

    function automatic logic mode_err(input mode_e mode);
        return (mode == MODE_RSVD);
    endfunction

endpackage

// File: rtl/seq_decoder_core.sv
// seq_decoder_core: combinational (code, mode) -> (word, err).
// Reserved mode yields an all-zero word with err set.
module seq_decoder_core
    import seq_decoder_pkg::*;
#(
    parameter int N = 3,
    parameter int W = 2**N
) (
    input  logic [N-1:0] code,
    input  logic [1:0]   mode,
    output logic [W-1:0] word,
    output logic         err
);

    logic [MAX_N-1:0] code_ext;
    mode_e            mode_t;

    assign code_ext = MAX_N'(code);
    assign mode_t   = mode_e'(mode);

    // Build the decoded word bit by bit from the shared rule.
    always_comb begin
        word = '0;
        for (int k = 0; k < W; k++) begin
            word[k] = decode_bit(code_ext, mode_t, MAX_N'(k));
        end
        err = mode_err(mode_t);
    end

endmodule

// File: rtl/seq_decoder.sv
// seq_decoder: decode on accept, then buffer in a 2-entry skid FIFO.
// in_ready depends only on occupancy (and reset), never on out_ready.
module seq_decoder
    import seq_decoder_pkg::*;
#(
    parameter int N = 3,
    parameter int W = 2**N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_code,
    input  logic [1:0]   in_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_d,
    output logic         out_err
);

    logic [W-1:0] dec_word;
    logic         dec_err;

    logic [W:0]   mem_q [2];
    logic [W:0]   mem_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         push, pop;
    logic [W:0]   head;

    seq_decoder_core #(
        .N (N),
        .W (W)
    ) u_core (
        .code (in_code),
        .mode (in_mode),
        .word (dec_word),
        .err  (dec_err)
    );

    assign in_ready  = !rst && (cnt_q != 2'd2);
    assign out_valid = (cnt_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign head      = mem_q[rd_ptr_q];
    assign out_d     = out_valid ? head[W-1:0] : '0;
    assign out_err   = out_valid && head[W];

    // Next FIFO state: store decoded word on push, advance head on pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = {dec_err, dec_word};
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // FIFO registers; reset discards everything and wins over push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_seq_decoder.sv
// tb_seq_decoder: directed vectors for seq_decoder (N=3).
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_seq_decoder;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_code;
    logic [1:0] in_mode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_d;
    logic       out_err;

    int n_chk;
    int n_pass;

    seq_decoder #(.N(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_d     (out_d),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_one(input logic [2:0] c,
                            input logic [1:0] m,
                            input logic [7:0] exp_d,
                            input logic       exp_e);
        in_code  = c;
        in_mode  = m;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("one_valid", 64'(out_valid), 64'd1);
        chk("one_d", 64'(out_d), 64'(exp_d));
        chk("one_err", 64'(out_err), 64'(exp_e));
        step();
        chk("one_drain", 64'(out_valid), 64'd0);
        chk("one_drain_d", 64'(out_d), 64'd0);
    endtask

    initial begin
        logic [7:0] e;
        logic [2:0] c;
        logic [1:0] m;
        n_chk     = 0;
        n_pass    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_code   = '0;
        in_mode   = '0;
        out_ready = 1'b1;

        step();
        step();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_d", 64'(out_d), 64'd0);
        chk("rst_err", 64'(out_err), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 64'(in_ready), 64'd1);

        // mode 0 sweep, back to back
        in_mode  = 2'd0;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_code = 3'(i);
            #1;
            chk("sweep_ready", 64'(in_ready), 64'd1);
            step();
            chk("sweep_valid", 64'(out_valid), 64'd1);
            chk("sweep_d", 64'(out_d), 64'd1 << i);
        end
        in_valid = 1'b0;
        step();
        chk("sweep_drain", 64'(out_valid), 64'd0);

        send_one(3'd5, 2'd1, 8'h3F, 1'b0);
        send_one(3'd3, 2'd2, 8'hF7, 1'b0);
        send_one(3'd2, 2'd3, 8'h00, 1'b1);
        send_one(3'd6, 2'd0, 8'h40, 1'b0);

        // backpressure and stall stability
        out_ready = 1'b0;
        in_mode   = 2'd0;
        in_code   = 3'd1;
        in_valid  = 1'b1;
        step();
        chk("bp_d1", 64'(out_d), 64'h02);
        chk("bp_ready1", 64'(in_ready), 64'd1);
        in_code = 3'd2;
        step();
        chk("bp_ready2", 64'(in_ready), 64'd0);
        chk("bp_d2", 64'(out_d), 64'h02);
        in_code = 3'd3;
        step();
        chk("bp_hold", 64'(out_d), 64'h02);
        in_code = 3'd7;
        in_mode = 2'd3;
        step();
        chk("stall_d", 64'(out_d), 64'h02);
        chk("stall_err", 64'(out_err), 64'd0);
        in_code   = 3'd3;
        in_mode   = 2'd0;
        out_ready = 1'b1;
        step();
        chk("rel_d2", 64'(out_d), 64'h04);
        chk("rel_ready", 64'(in_ready), 64'd1);
        step();
        chk("rel_d3", 64'(out_d), 64'h08);
        in_valid = 1'b0;
        step();
        chk("rel_drain", 64'(out_valid), 64'd0);

        // steady state push+pop at cnt=1, 16 words
        in_valid = 1'b1;
        for (int j = 0; j < 16; j++) begin
            c = 3'((j * 3) % 8);
            m = (j % 2 == 0) ? 2'd0 : 2'd2;
            e = 8'd1 << c;
            if (m == 2'd2) e = ~e;
            in_code = c;
            in_mode = m;
            step();
            chk("tp_valid", 64'(out_valid), 64'd1);
            chk("tp_ready", 64'(in_ready), 64'd1);
            chk("tp_d", 64'(out_d), 64'(e));
        end
        in_valid = 1'b0;
        step();
        chk("tp_drain", 64'(out_valid), 64'd0);

        // reset at cnt=2 discards both words
        out_ready = 1'b0;
        in_mode   = 2'd0;
        in_code   = 3'd4;
        in_valid  = 1'b1;
        step();
        in_code = 3'd5;
        step();
        chk("full_ready", 64'(in_ready), 64'd0);
        chk("full_d", 64'(out_d), 64'h10);
        rst       = 1'b1;
        out_ready = 1'b1;
        step();
        chk("mrst_valid", 64'(out_valid), 64'd0);
        chk("mrst_d", 64'(out_d), 64'd0);
        chk("mrst_err", 64'(out_err), 64'd0);
        chk("mrst_ready", 64'(in_ready), 64'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("mrst_rel_ready", 64'(in_ready), 64'd1);
        step();
        chk("mrst_no_old", 64'(out_valid), 64'd0);
        in_code  = 3'd6;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("mrst_new_d", 64'(out_d), 64'h40);
        step();
        chk("mrst_final", 64'(out_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
